// File: rtl/change_dispenser_if.sv
// Coin-return bus between the vending FSM, the change dispenser and the two hoppers.
// The master drives vend/change/done; the dispenser (slave) drives the hopper requests and status.
interface change_dispenser_if #(
  parameter int PEND_W = 4
);
  logic              vend;
  logic [1:0]        change;
  logic              done;
  logic              eject5;
  logic              eject10;
  logic              busy;
  logic              fault;
  logic              overflow;
  logic [PEND_W-1:0] pending;

  modport master (
    output vend, change, done,
    input  eject5, eject10, busy, fault, overflow, pending
  );

  modport slave (
    input  vend, change, done,
    output eject5, eject10, busy, fault, overflow, pending
  );
endinterface

// File: rtl/change_dispenser.sv
// Accumulates change owed in 5-unit coins and ejects it one coin at a time; outputs are registered.
// Each coin waits on the hopper's done; a missing done past TIMEOUT cycles latches a terminal jam fault.
module change_dispenser #(
  parameter int PEND_W  = 4,
  parameter int TIMEOUT = 16,
  parameter int MIN_GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  change_dispenser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EJECT, GAP, FAULT} state_t;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic              coin10_q, coin10_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              fault_q, fault_d;
  logic              ovf_q, ovf_d;
  logic              ej5_q, ej5_d;
  logic              ej10_q, ej10_d;
  logic              busy_q, busy_d;

  logic [1:0]        add, dec;
  logic [PEND_W+1:0] sum;

  always_comb begin
    state_d  = state_q;
    coin10_d = coin10_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    fault_d  = fault_q;
    ovf_d    = ovf_q;
    dec      = 2'd0;
    add      = (bus.vend && bus.change != 2'd3) ? bus.change : 2'd0;

    case (state_q)
      IDLE: begin
        // Coin choice uses registered pending, so its value never exceeds what is owed.
        if (pending_q != '0) begin
          state_d  = EJECT;
          coin10_d = (pending_q >= PEND_W'(2));
          tmo_d    = '0;
        end
      end
      EJECT: begin
        if (bus.done) begin
          dec     = coin10_q ? 2'd2 : 2'd1;
          state_d = GAP;
          tmo_d   = '0;
          gap_d   = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = FAULT;
          fault_d = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(MIN_GAP - 1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: ;
    endcase

    sum = (PEND_W+2)'(pending_q) + (PEND_W+2)'(add) - (PEND_W+2)'(dec);
    if (sum > (PEND_W+2)'(PEND_MAX)) begin
      pending_d = PEND_MAX;
      ovf_d     = 1'b1;
    end else begin
      pending_d = sum[PEND_W-1:0];
    end

    ej5_d  = (state_d == EJECT) && !coin10_d;
    ej10_d = (state_d == EJECT) &&  coin10_d;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      coin10_q  <= 1'b0;
      tmo_q     <= '0;
      gap_q     <= '0;
      pending_q <= '0;
      fault_q   <= 1'b0;
      ovf_q     <= 1'b0;
      ej5_q     <= 1'b0;
      ej10_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      coin10_q  <= coin10_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      fault_q   <= fault_d;
      ovf_q     <= ovf_d;
      ej5_q     <= ej5_d;
      ej10_q    <= ej10_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.eject5   = ej5_q;
  assign bus.eject10  = ej10_q;
  assign bus.busy     = busy_q;
  assign bus.fault    = fault_q;
  assign bus.overflow = ovf_q;
  assign bus.pending  = pending_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: accumulation, coin choice, jam fault, saturation, async reset.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  change_dispenser_if #(.PEND_W(4)) bus ();

  change_dispenser #(.PEND_W(4), .TIMEOUT(16), .MIN_GAP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_eject();
    for (int i = 0; i < 20; i++) begin
      if (bus.eject5 || bus.eject10) break;
      tick();
    end
  endtask

  initial begin
    bus.vend   = 1'b0;
    bus.change = 2'd0;
    bus.done   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_pending", 32'(bus.pending), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_eject", 32'({bus.eject5, bus.eject10}), 0);
    check("rst_flags", 32'({bus.fault, bus.overflow}), 0);
    rst = 1'b1;
    tick();

    // 1: single 10-coin
    bus.vend = 1'b1; bus.change = 2'd2;
    tick();
    bus.vend = 1'b0; bus.change = 2'd0;
    check("t1_pending2", 32'(bus.pending), 2);
    check("t1_no_eject_yet", 32'(bus.eject10), 0);
    tick();
    check("t1_eject10", 32'(bus.eject10), 1);
    check("t1_eject5_low", 32'(bus.eject5), 0);
    check("t1_busy", 32'(bus.busy), 1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("t1_pending0", 32'(bus.pending), 0);
    check("t1_eject_drop", 32'(bus.eject10), 0);
    tick();
    check("t1_gap_busy", 32'(bus.busy), 1);
    tick();
    check("t1_idle", 32'(bus.busy), 0);

    // 2: 5-coin chosen at pending=1, then 10-coin
    bus.vend = 1'b1; bus.change = 2'd1;
    tick();
    bus.vend = 1'b0; bus.change = 2'd0;
    check("t2_pending1", 32'(bus.pending), 1);
    tick();
    check("t2_eject5", 32'(bus.eject5), 1);
    bus.vend = 1'b1; bus.change = 2'd2;
    tick();
    bus.vend = 1'b0; bus.change = 2'd0;
    check("t2_pending3", 32'(bus.pending), 3);
    check("t2_still_eject5", 32'({bus.eject5, bus.eject10}), 2);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("t2_pending2", 32'(bus.pending), 2);
    wait_eject();
    check("t2_eject10", 32'({bus.eject5, bus.eject10}), 1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("t2_pending0", 32'(bus.pending), 0);
    tick();
    tick();
    check("t2_idle", 32'(bus.busy), 0);

    // 3: jam timeout
    bus.vend = 1'b1; bus.change = 2'd1;
    tick();
    bus.vend = 1'b0; bus.change = 2'd0;
    tick();
    check("t3_eject5", 32'(bus.eject5), 1);
    for (int i = 0; i < 15; i++) tick();
    check("t3_eject_held", 32'(bus.eject5), 1);
    check("t3_no_fault_yet", 32'(bus.fault), 0);
    tick();
    check("t3_fault", 32'(bus.fault), 1);
    check("t3_eject_drop", 32'({bus.eject5, bus.eject10}), 0);
    check("t3_busy", 32'(bus.busy), 1);
    check("t3_pending1", 32'(bus.pending), 1);
    bus.vend = 1'b1; bus.change = 2'd2;
    tick();
    bus.vend = 1'b0; bus.change = 2'd0;
    check("t3_pending3", 32'(bus.pending), 3);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check("t3_done_ignored", 32'(bus.pending), 3);
    check("t3_no_eject", 32'({bus.eject5, bus.eject10}), 0);
    check("t3_fault_sticky", 32'(bus.fault), 1);
    rst = 1'b0;
    #1;
    check("t3_rst_fault", 32'(bus.fault), 0);
    tick();
    rst = 1'b1;
    tick();

    // 4: saturation and drain
    for (int i = 0; i < 8; i++) begin
      bus.vend = 1'b1; bus.change = 2'd2;
      tick();
    end
    bus.vend = 1'b0; bus.change = 2'd0;
    check("t4_saturated", 32'(bus.pending), 15);
    check("t4_overflow", 32'(bus.overflow), 1);
    for (int k = 0; k < 8; k++) begin
      wait_eject();
      check($sformatf("t4_coin%0d", k), 32'({bus.eject5, bus.eject10}), (k < 7) ? 1 : 2);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check($sformatf("t4_pend%0d", k), 32'(bus.pending), (k < 7) ? 13 - 2 * k : 0);
    end
    tick();
    tick();
    check("t4_idle", 32'(bus.busy), 0);
    check("t4_overflow_sticky", 32'(bus.overflow), 1);

    // 5: done and vend on the same edge
    bus.vend = 1'b1; bus.change = 2'd2;
    tick();
    bus.vend = 1'b0; bus.change = 2'd0;
    tick();
    check("t5_eject10", 32'(bus.eject10), 1);
    bus.done = 1'b1; bus.vend = 1'b1; bus.change = 2'd1;
    tick();
    bus.done = 1'b0; bus.vend = 1'b0; bus.change = 2'd0;
    check("t5_pending1", 32'(bus.pending), 1);
    wait_eject();
    check("t5_eject5", 32'({bus.eject5, bus.eject10}), 2);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("t5_pending0", 32'(bus.pending), 0);
    tick();
    tick();

    // 6: asynchronous reset mid-EJECT, then invalid change code
    bus.vend = 1'b1; bus.change = 2'd2;
    tick();
    bus.vend = 1'b0; bus.change = 2'd0;
    tick();
    check("t6_eject10", 32'(bus.eject10), 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_eject", 32'({bus.eject5, bus.eject10}), 0);
    check("t6_async_busy", 32'(bus.busy), 0);
    check("t6_async_pending", 32'(bus.pending), 0);
    check("t6_async_flags", 32'({bus.fault, bus.overflow}), 0);
    tick();
    rst = 1'b1;
    bus.vend = 1'b1; bus.change = 2'd3;
    tick();
    bus.vend = 1'b0; bus.change = 2'd0;
    check("t6_invalid_code", 32'(bus.pending), 0);
    tick();
    check("t6_stay_idle", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sits downstream of the vending machine FSM and consumes its vend pulse and change code.
- Accumulates change owed, in 5-unit coins, and drives two coin hoppers (5 and 10) one coin at a time.
- Each coin uses an eject/done handshake, with a jam timeout and a minimum gap between coins.
- Closes the coin-return side of the coin protocol: the vending machine accepts coins, this block returns them.

Parameters:
- PEND_W, 4: width of the pending-change counter, in 5-unit coins. Max pending = 2^PEND_W-1.
- TIMEOUT, 16: cycles eject may stay asserted without done before a jam fault.
- MIN_GAP, 2: idle cycles forced after each completed coin.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- vend  in  1  one-cycle vend pulse from the vending machine.
- change  in  2  change code, valid only when vend=1. 0=none, 1=5, 2=10, 3=invalid (treated as 0).
- done  in  1  hopper pulse: the currently requested coin has been ejected.
- eject5  out  1  request one 5-coin; held until done or timeout.
- eject10  out  1  request one 10-coin; held until done or timeout.
- busy  out  1  high whenever state is not IDLE.
- fault  out  1  sticky jam flag.
- overflow  out  1  sticky flag: a change add saturated the pending counter.
- pending  out  PEND_W  coins (5-units) still owed.

Behaviour:

Reset (rst=0, async):
- State goes to IDLE.
- All outputs are 0.
- Timeout and gap counters are 0.
- Reset mid-eject drops eject immediately and discards pending.

Accumulate:
- When vend=1 is sampled at an edge, add = change (1 or 2 units, or 0 for codes 0 and 3).
- When vend=0, change is ignored.

Pending update, every edge:
- pending_next = pending + add - dec.
- dec = coin value (1 or 2) on the edge where done is accepted in EJECT, else 0.
- An add and a dec on the same edge are both applied.
- If the result exceeds 2^PEND_W-1, pending saturates at max and overflow sets.
- overflow is cleared only by reset.

FSM states: IDLE, EJECT, GAP, FAULT.
- IDLE: if pending != 0, go to EJECT.
  - Latch the coin type on that edge: 10-coin if pending >= 2, else 5-coin.
  - The IDLE test uses the registered pending, so eject asserts one cycle after pending first becomes nonzero.
- EJECT: exactly one of eject5/eject10 is high; the timeout counter increments each cycle.
  - done=1: decrement pending by the coin value, drop eject, clear the counter, go to GAP.
  - Counter reaches TIMEOUT with done=0: drop eject, set fault, go to FAULT.
  - done and timeout on the same edge: done wins.
- GAP: hold MIN_GAP cycles with eject low, then go to IDLE.
- FAULT: terminal until reset.
  - eject5/eject10 stay 0 and busy stays 1.
  - pending keeps accumulating vend additions.
- done outside EJECT is ignored.

Outputs:
- All outputs are registered.
- eject5 and eject10 are never high together.
- eject5/eject10 reflect the latched coin type for the whole EJECT stay.

Arithmetic:
- pending is unsigned.
- The decrement never underflows, because the coin type is chosen so that its value is <= pending at selection, and pending only grows afterwards.

Test Plan:
1. Reset, then vend=1 with change=2 for one cycle.
   - pending=2 one edge later.
   - eject10=1 one edge after that.
   - done pulse → pending=0, busy low after 2 GAP cycles plus 1.
2. vend with change=1, then vend with change=2 two cycles later.
   - First coin is eject5 (pending was 1 at selection).
   - Then eject10.
   - pending sequence 1→3→2→0.
3. vend change=1 with done held low for 16 EJECT cycles.
   - eject5 drops, fault=1, busy=1, pending=1.
   - A later vend change=2 gives pending=3, with no eject.
4. PEND_W=4: eight vends with change=2.
   - pending saturates at 15 and overflow=1.
   - The dispenser then drains 10,10,…,10,5.
   - overflow remains 1.
5. Same-edge done (10-coin) and vend change=1 at pending=2.
   - pending=1 next cycle; neither update is lost.
6. Assert rst=0 asynchronously mid-EJECT, between clock edges.
   - eject, busy, pending and fault go to 0 immediately.
   - change=3 with vend=1 after reset leaves pending=0.
